// File: rtl/bit_count_controller_if.sv
// Command channel into the bit counter sequencer: valid/ready handshake plus
// the opcode, its argument and the prescale divider sampled at run start.
interface bit_count_controller_if #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [WIDTH-1:0]      cmd_arg;
  logic [PRESCALE_W-1:0] div;

  modport master (output cmd_valid, cmd_op, cmd_arg, div, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_arg, div, output cmd_ready);
endinterface

// File: rtl/bit_count_controller.sv
// Command-driven sequencer owning the WIDTH-bit count register: clear, load,
// counted or free runs with a prescaler, pause and abort.
module bit_count_controller #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  bit_count_controller_if.slave  cmd,
  input  logic                   pause,
  input  logic                   abort,
  output logic [WIDTH-1:0]       count,
  output logic                   busy,
  output logic                   done,
  output logic                   wrap
);

  localparam logic [1:0] OP_CLEAR    = 2'b00;
  localparam logic [1:0] OP_LOAD     = 2'b01;
  localparam logic [1:0] OP_RUN_N    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH-1:0]      r_count;
  logic [WIDTH-1:0]      r_rem;
  logic [PRESCALE_W-1:0] r_pre;
  logic [PRESCALE_W-1:0] r_div_q;
  logic                  r_free;
  logic                  r_wrap;
  logic                  w_accept;
  logic                  w_tick;
  logic                  w_step;

  assign cmd.cmd_ready = !rst && (r_state == S_IDLE);
  assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;
  assign w_tick        = (r_pre == r_div_q);

  // A PAUSE cycle with pause released acts as a RUN cycle, so a run is
  // delayed by exactly the number of cycles pause was held high.
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && cmd.cmd_op[1]) begin
          if (cmd.cmd_op == OP_RUN_N && cmd.cmd_arg == '0) w_state_nxt = S_DONE;
          else                                             w_state_nxt = S_RUN;
        end
      end
      S_RUN, S_PAUSE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (pause) begin
          w_state_nxt = S_PAUSE;
        end else begin
          w_step      = 1'b1;
          w_state_nxt = S_RUN;
          if (w_tick && !r_free && r_rem == WIDTH'(1)) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_rem   <= '0;
      r_pre   <= '0;
      r_div_q <= '0;
      r_free  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wrap  <= 1'b0;
      if (w_accept) begin
        case (cmd.cmd_op)
          OP_CLEAR: r_count <= '0;
          OP_LOAD:  r_count <= cmd.cmd_arg;
          default: begin
            r_rem   <= cmd.cmd_arg;
            r_div_q <= cmd.div;
            r_pre   <= '0;
            r_free  <= cmd.cmd_op[0];
          end
        endcase
      end
      if (w_step) begin
        if (w_tick) begin
          r_pre   <= '0;
          r_count <= r_count + WIDTH'(1);
          r_rem   <= r_rem - WIDTH'(1);
          r_wrap  <= &r_count;
        end else begin
          r_pre <= r_pre + PRESCALE_W'(1);
        end
      end
    end
  end

  assign count = r_count;
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_bit_count_controller.sv
// Scoreboard bench for bit_count_controller: each scenario queues the expected
// per-cycle outputs while driving commands, then drains the queue cycle by cycle.
module tb_bit_count_controller;
  localparam int WIDTH      = 4;
  localparam int PRESCALE_W = 8;
  localparam logic [1:0] OP_CLEAR = 2'b00, OP_LOAD = 2'b01, OP_RUN_N = 2'b10, OP_RUN_FREE = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             wrap;

  bit_count_controller_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bif ();

  bit_count_controller #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .cmd   (bif),
    .pause (pause),
    .abort (abort),
    .count (count),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;
    logic             wrap;
    logic             rdy;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input logic [WIDTH-1:0] c, input logic b, input logic d, input logic w);
    exp_t e;
    e.cnt = c; e.busy = b; e.done = d; e.wrap = w; e.rdy = ~b;
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o.cnt = count; o.busy = busy; o.done = done; o.wrap = wrap; o.rdy = bif.cmd_ready;
    return o;
  endfunction

  function automatic string fmt(input exp_t v);
    return $sformatf("cnt=%0d busy=%b done=%b wrap=%b rdy=%b", v.cnt, v.busy, v.done, v.wrap, v.rdy);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] arg, input logic [PRESCALE_W-1:0] d);
    bif.cmd_valid = 1'b1;
    bif.cmd_op    = op;
    bif.cmd_arg   = arg;
    bif.div       = d;
    step();
    bif.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pause = 1'b0; abort = 1'b0;
    bif.cmd_valid = 1'b0; bif.cmd_op = OP_CLEAR; bif.cmd_arg = '0; bif.div = '0;
    step(); step();
    checks++;
    if ({count, busy, done, wrap} !== 7'd0) begin
      errors++; $display("FAIL reset_outputs got cnt=%0d busy=%b done=%b wrap=%b exp all zero", count, busy, done, wrap);
    end
    checks++;
    if (bif.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low got %b exp 0", bif.cmd_ready);
    end
    rst = 1'b0; #1;
    checks++;
    if (bif.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_high got %b exp 1", bif.cmd_ready);
    end
    issue(OP_LOAD, 4'd3, 8'd0);
    issue(OP_RUN_FREE, 4'd0, 8'd3);
    step(); step();
    checks++;
    if (count !== 4'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL midrun_pre got cnt=%0d busy=%b exp cnt=3 busy=1", count, busy);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({count, busy, done, wrap, bif.cmd_ready} !== 8'd0) begin
      errors++; $display("FAIL midrun_reset got cnt=%0d busy=%b done=%b wrap=%b rdy=%b exp all zero",
                         count, busy, done, wrap, bif.cmd_ready);
    end
    rst = 1'b0; #1;
    checks++;
    if (bif.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL midrun_ready got %b exp 1", bif.cmd_ready);
    end
  endtask

  task automatic test_run_n();
    exp_t e, o;
    int   i = 0;
    issue(OP_CLEAR, 4'd9, 8'd0);
    checks++;
    if (count !== 4'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL clear got cnt=%0d wrap=%b exp cnt=0 wrap=0", count, wrap);
    end
    issue(OP_RUN_N, 4'd5, 8'd0);
    exp_q.push_back(mk(4'd0, 1'b1, 1'b0, 1'b0));
    for (int k = 1; k <= 4; k++) exp_q.push_back(mk(WIDTH'(k), 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd5, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(4'd5, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd5, 1'b0, 1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL run_n[%0d] got %s exp %s", i, fmt(o), fmt(e)); end
      if (exp_q.size() > 0) step();
      i++;
    end
  endtask

  task automatic test_wrap();
    exp_t e, o;
    int   i = 0;
    issue(OP_LOAD, 4'd14, 8'd0);
    checks++;
    if (count !== 4'd14 || wrap !== 1'b0) begin
      errors++; $display("FAIL load got cnt=%0d wrap=%b exp cnt=14 wrap=0", count, wrap);
    end
    issue(OP_RUN_N, 4'd3, 8'd0);
    exp_q.push_back(mk(4'd14, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd15, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd0,  1'b1, 1'b0, 1'b1));
    exp_q.push_back(mk(4'd1,  1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(4'd1,  1'b0, 1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL wrap[%0d] got %s exp %s", i, fmt(o), fmt(e)); end
      if (exp_q.size() > 0) step();
      i++;
    end
  endtask

  task automatic test_prescale();
    exp_t e, o;
    int   i = 0;
    issue(OP_RUN_N, 4'd2, 8'd2);
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(4'd1, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(4'd2, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd3, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(4'd3, 1'b0, 1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL prescale[%0d] got %s exp %s", i, fmt(o), fmt(e)); end
      bif.cmd_valid = (i + 1 == 2);
      bif.cmd_op    = OP_LOAD;
      bif.cmd_arg   = 4'd9;
      if (exp_q.size() > 0) step();
      i++;
    end
    bif.cmd_valid = 1'b0;
  endtask

  task automatic test_pause();
    exp_t e, o;
    int   i = 0;
    issue(OP_RUN_N, 4'd4, 8'd0);
    exp_q.push_back(mk(4'd3, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd4, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(4'd5, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd6, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd7, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(4'd7, 1'b0, 1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL pause[%0d] got %s exp %s", i, fmt(o), fmt(e)); end
      pause = (i + 1 >= 3) && (i + 1 <= 6);
      if (exp_q.size() > 0) step();
      i++;
    end
    pause = 1'b0;
  endtask

  task automatic test_abort();
    exp_t e, o;
    int   i = 0;
    issue(OP_RUN_N, 4'd2, 8'd0);
    exp_q.push_back(mk(4'd7, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd8, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd8, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd8, 1'b0, 1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL abort[%0d] got %s exp %s", i, fmt(o), fmt(e)); end
      abort = (i + 1 == 2);
      if (exp_q.size() > 0) step();
      i++;
    end
    abort = 1'b0;
    i = 0;
    issue(OP_RUN_N, 4'd0, 8'd5);
    exp_q.push_back(mk(4'd8, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(4'd8, 1'b0, 1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL run_zero[%0d] got %s exp %s", i, fmt(o), fmt(e)); end
      if (exp_q.size() > 0) step();
      i++;
    end
  endtask

  task automatic test_run_free();
    exp_t e, o;
    int   i = 0;
    issue(OP_LOAD, 4'd13, 8'd0);
    issue(OP_RUN_FREE, 4'd1, 8'd0);
    exp_q.push_back(mk(4'd13, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd14, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd15, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd0,  1'b1, 1'b0, 1'b1));
    exp_q.push_back(mk(4'd1,  1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd2,  1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd3,  1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd3,  1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(4'd3,  1'b0, 1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL run_free[%0d] got %s exp %s", i, fmt(o), fmt(e)); end
      abort = (i + 1 == 7);
      if (exp_q.size() > 0) step();
      i++;
    end
    abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    int   i = 0;
    issue(OP_CLEAR, 4'd0, 8'd0);
    bif.cmd_valid = 1'b1; bif.cmd_op = OP_RUN_N; bif.cmd_arg = 4'd1; bif.div = 8'd0;
    step();
    exp_q.push_back(mk(4'd0, 1'b1, 1'b0, 1'b0));
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(mk(WIDTH'(k), 1'b1, 1'b1, 1'b0));
      exp_q.push_back(mk(WIDTH'(k), 1'b0, 1'b0, 1'b0));
      if (k < 3) exp_q.push_back(mk(WIDTH'(k), 1'b1, 1'b0, 1'b0));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back[%0d] got %s exp %s", i, fmt(o), fmt(e)); end
      bif.cmd_valid = (i + 1 <= 6);
      if (exp_q.size() > 0) step();
      i++;
    end
    bif.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_run_n();
    test_wrap();
    test_prescale();
    test_pause();
    test_abort();
    test_run_free();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
